fpu_op_scheduler: RTL and testbench

In-order dispatcher that queues FPU operation commands and sequences them onto a set of go/done FPU units, such as the linear-layer gradient engines, one operation at a time. It sits between the command decoder and the FPU units. It owns each unit's `go` line, enforces the full four-phase go/done handshake, detects hung units with a watchdog, and reports each completion with its tag.

---
 rtl/fpu_op_scheduler_if.sv | 34 +++
 rtl/fpu_op_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_fpu_op_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_op_scheduler_if.sv
// Command, unit go/done and completion signals of the FPU op scheduler.
// Latency: none, wiring only.
// Backpressure: cmd_valid/cmd_ready on the command side, four-phase go/done toward the units.
interface fpu_op_scheduler_if #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 8
);
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [UW-1:0]        cmd_unit;
    logic [TAG_W-1:0]     cmd_tag;
    logic [NUM_UNITS-1:0] unit_go;
    logic [NUM_UNITS-1:0] unit_done;
    logic                 cpl_valid;
    logic [TAG_W-1:0]     cpl_tag;
    logic [UW-1:0]        cpl_unit;
    logic                 cpl_err;
    logic                 busy;
    logic [15:0]          ops_done;

    // Command source and FPU units.
    modport master (
        output cmd_valid, cmd_unit, cmd_tag, unit_done,
        input  cmd_ready, unit_go, cpl_valid, cpl_tag, cpl_unit, cpl_err, busy, ops_done
    );

    // The scheduler itself.
    modport slave (
        input  cmd_valid, cmd_unit, cmd_tag, unit_done,
        output cmd_ready, unit_go, cpl_valid, cpl_tag, cpl_unit, cpl_err, busy, ops_done
    );
endinterface

// File: rtl/fpu_op_scheduler.sv
// Generic synchronous FIFO, head visible combinationally on dout.
// Latency: a pushed entry is at the head the cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty.
module sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Storage write; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// In-order dispatcher: queues FPU commands, runs a four-phase go/done handshake per op.
// Latency: pop one edge after accept, go high from then; cpl one cycle after done falls.
// Backpressure: cmd_ready = !full (a same-cycle pop does not free space); one op in flight.
module fpu_op_scheduler #(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst_l,
    fpu_op_scheduler_if.slave bus
);
    localparam int UW  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int WDW = $clog2(TIMEOUT);

    typedef struct packed {
        logic [UW-1:0]    unit;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, COMPLETE} state_t;

    state_t               state;
    cmd_t                 push_dat;
    cmd_t                 head_dat;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push_vld;
    logic                 pop_vld;
    logic                 head_bad;
    logic [UW-1:0]        cur_unit;
    logic [TAG_W-1:0]     cur_tag;
    logic                 err;
    logic [WDW-1:0]       wd;
    logic                 wd_hit;
    logic [NUM_UNITS-1:0] cur_sel;
    logic                 cur_done;
    logic                 cpl_valid_r;
    logic [TAG_W-1:0]     cpl_tag_r;
    logic [UW-1:0]        cpl_unit_r;
    logic                 cpl_err_r;
    logic [15:0]          ops_done_r;

    assign push_dat.unit = bus.cmd_unit;
    assign push_dat.tag  = bus.cmd_tag;
    assign push_vld      = bus.cmd_valid && !fifo_full;
    assign pop_vld       = (state == IDLE) && !fifo_empty;

    sched_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_l (rst_l),
        .push  (push_vld),
        .din   (push_dat),
        .pop   (pop_vld),
        .dout  (head_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Unit index is one bit wider in the compare so NUM_UNITS = 2**UW still fits.
    assign head_bad = ({1'b0, head_dat.unit} >= (UW+1)'(NUM_UNITS));
    assign wd_hit   = (wd == WDW'(TIMEOUT - 1));

    // One-hot select of the current unit; out-of-range indices select nothing.
    always_comb begin
        cur_sel = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cur_sel[i] = (cur_unit == UW'(i));
        end
    end

    assign cur_done = |(bus.unit_done & cur_sel);

    // Dispatch FSM with watchdog, completion registers and op counter.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state       <= IDLE;
            cur_unit    <= '0;
            cur_tag     <= '0;
            err         <= 1'b0;
            wd          <= '0;
            cpl_valid_r <= 1'b0;
            cpl_tag_r   <= '0;
            cpl_unit_r  <= '0;
            cpl_err_r   <= 1'b0;
            ops_done_r  <= '0;
        end else begin
            cpl_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (!fifo_empty) begin
                        cur_unit <= head_dat.unit;
                        cur_tag  <= head_dat.tag;
                        if (head_bad) begin
                            // Illegal unit: report straight away, never touch a go line.
                            err         <= 1'b1;
                            state       <= COMPLETE;
                            cpl_valid_r <= 1'b1;
                            cpl_tag_r   <= head_dat.tag;
                            cpl_unit_r  <= head_dat.unit;
                            cpl_err_r   <= 1'b1;
                        end else begin
                            err   <= 1'b0;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cur_done || wd_hit) begin
                        // done wins over a watchdog expiring in the same cycle.
                        err   <= !cur_done;
                        state <= RELEASE;
                        wd    <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!cur_done || wd_hit) begin
                        // Still seeing done here means the watchdog fired.
                        err         <= err | cur_done;
                        state       <= COMPLETE;
                        wd          <= '0;
                        cpl_valid_r <= 1'b1;
                        cpl_tag_r   <= cur_tag;
                        cpl_unit_r  <= cur_unit;
                        cpl_err_r   <= err | cur_done;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                COMPLETE: begin
                    state <= IDLE;
                    if (!err && (ops_done_r != 16'hFFFF)) begin
                        ops_done_r <= ops_done_r + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.unit_go   = (state == ISSUE) ? cur_sel : '0;
    assign bus.cpl_valid = cpl_valid_r;
    assign bus.cpl_tag   = cpl_tag_r;
    assign bus.cpl_unit  = cpl_unit_r;
    assign bus.cpl_err   = cpl_err_r;
    assign bus.busy      = (state != IDLE) || !fifo_empty;
    assign bus.ops_done  = ops_done_r;
endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Bench for fpu_op_scheduler: vector table, FIFO-full and reset sequences, random traffic.
// Latency: n/a.
// Backpressure: unit models answer go with configurable done behaviour.
module tb_fpu_op_scheduler;
    localparam int NU = 3;
    localparam int TW = 8;
    localparam int TO = 16;
    localparam int DP = 4;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_STUCK  = 2;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    fpu_op_scheduler_if #(.NUM_UNITS(NU), .TAG_W(TW)) bus ();

    fpu_op_scheduler #(.NUM_UNITS(NU), .DEPTH(DP), .TAG_W(TW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Unit models: NORMAL raises done after delay+1 go cycles and drops it when go falls,
    // NEVER ignores go, STUCK raises done the same way but never drops it.
    int umode [NU];
    int udelay[NU];
    int ucnt  [NU];
    logic [NU-1:0] done_r;

    always @(negedge clk) begin
        for (int i = 0; i < NU; i++) begin
            if (!rst_l) begin
                ucnt[i]   = 0;
                done_r[i] = 1'b0;
            end else if (bus.unit_go[i]) begin
                ucnt[i]++;
                if (umode[i] != MODE_NEVER && ucnt[i] > udelay[i]) done_r[i] = 1'b1;
            end else begin
                ucnt[i] = 0;
                if (umode[i] != MODE_STUCK) done_r[i] = 1'b0;
            end
        end
        bus.unit_done = done_r;
    end

    // Reference model: every accepted command completes in order; it errors if the
    // unit does not exist or its unit never finishes a clean handshake within TO.
    typedef struct {
        logic [1:0] unit;
        logic [7:0] tag;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   exp_ops = 0;
    int   cpl_seen = 0;
    bit   ops_pending = 0;
    bit   had_go = 0;
    int   low_run = 0;
    logic [NU-1:0] prev_go = '0;

    function automatic logic exp_err_f(input logic [1:0] u);
        int idx;
        idx = int'(u);
        if (idx >= NU) return 1'b1;
        return (umode[idx] != MODE_NORMAL) || (udelay[idx] >= TO);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_l) begin
            q.delete();
            exp_ops     = 0;
            ops_pending = 0;
            had_go      = 0;
            low_run     = 0;
            prev_go     = '0;
        end else begin
            if (ops_pending) begin
                check("ops_done", 32'(bus.ops_done), exp_ops);
                ops_pending = 0;
            end
            if (bus.cpl_valid) begin
                cpl_seen++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cpl: got tag %0h, required no completion", bus.cpl_tag);
                end else begin
                    e = q.pop_front();
                    check("cpl_tag", 32'(bus.cpl_tag), 32'(e.tag));
                    check("cpl_unit", 32'(bus.cpl_unit), 32'(e.unit));
                    check("cpl_err", 32'(bus.cpl_err), 32'(e.err));
                    if (!e.err && exp_ops < 65535) exp_ops++;
                    ops_pending = 1;
                end
            end
            if (bus.unit_go != '0) begin
                if (prev_go == '0 && had_go) check("go_gap_ge2", 32'(low_run >= 2), 1);
                had_go  = 1;
                low_run = 0;
                if ($countones(bus.unit_go) > 1) begin
                    checks++;
                    errors++;
                    $display("FAIL go_onehot: got %b, required at most one bit", bus.unit_go);
                end
            end else begin
                low_run++;
            end
            prev_go = bus.unit_go;
            if (bus.cmd_valid && bus.cmd_ready) begin
                e.unit = bus.cmd_unit;
                e.tag  = bus.cmd_tag;
                e.err  = exp_err_f(bus.cmd_unit);
                q.push_back(e);
            end
        end
    end

    task automatic push(input logic [1:0] u, input logic [7:0] t);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_unit  = u;
        bus.cmd_tag   = t;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got cmd_ready=0 for 300 cycles, required 1");
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1;
                break;
            end
        end
        check(name, 32'(ok), 1);
        @(negedge clk);
        check({name, "_queue"}, q.size(), 0);
    endtask

    typedef struct {
        logic [1:0] unit;
        logic [7:0] tag;
        int         mode;
        int         delay;
        int         go;
        int         lat;
        logic       err;
    } vec_t;

    vec_t vt[9];

    task automatic run_vec(input vec_t v);
        int gocnt, lat;
        logic [7:0] tag;
        logic err;
        logic [2:0] m;
        m = 3'b001 << v.unit;
        gocnt = 0;
        lat = 0;
        tag = '0;
        err = 1'b0;
        if (int'(v.unit) < NU) begin
            umode[v.unit]  = v.mode;
            udelay[v.unit] = v.delay;
        end
        push(v.unit, v.tag);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.unit_go != '0) begin
                gocnt++;
                check("vec_go_target", 32'(bus.unit_go), 32'(m));
            end
            if (bus.cpl_valid) begin
                lat = k;
                tag = bus.cpl_tag;
                err = bus.cpl_err;
                check("vec_busy_at_cpl", 32'(bus.busy), 1);
                break;
            end
        end
        check("vec_latency", lat, v.lat);
        check("vec_go_cycles", gocnt, v.go);
        check("vec_tag", 32'(tag), 32'(v.tag));
        check("vec_err", 32'(err), 32'(v.err));
        @(negedge clk);
        check("vec_busy_after", 32'(bus.busy), 0);
        if (int'(v.unit) < NU) begin
            umode[v.unit]  = MODE_NORMAL;
            udelay[v.unit] = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, cpl_c;
        bit stall_seen;

        // unit, tag, mode, delay, go cycles, cycles accept->cpl, err
        vt[0] = '{2'd2, 8'h5A, MODE_NORMAL, 3,  4,  7, 1'b0};
        vt[1] = '{2'd0, 8'h01, MODE_NORMAL, 0,  1,  4, 1'b0};
        vt[2] = '{2'd1, 8'h33, MODE_NORMAL, 1,  2,  5, 1'b0};
        vt[3] = '{2'd3, 8'h11, MODE_NORMAL, 0,  0,  2, 1'b1};
        vt[4] = '{2'd1, 8'h77, MODE_NEVER,  0, 16, 19, 1'b1};
        vt[5] = '{2'd1, 8'h78, MODE_NORMAL, 2,  3,  6, 1'b0};
        vt[6] = '{2'd0, 8'hC3, MODE_NORMAL, 15, 16, 19, 1'b0};
        vt[7] = '{2'd0, 8'hC4, MODE_NORMAL, 16, 16, 19, 1'b1};
        vt[8] = '{2'd2, 8'hE5, MODE_STUCK,  2,  3, 21, 1'b1};

        bus.cmd_valid = 1'b0;
        bus.cmd_unit  = '0;
        bus.cmd_tag   = '0;
        for (int i = 0; i < NU; i++) begin
            umode[i]  = MODE_NORMAL;
            udelay[i] = 0;
        end

        repeat (3) @(posedge clk);
        #2 rst_l = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_unit_go", 32'(bus.unit_go), 0);
        check("rst_cpl_valid", 32'(bus.cpl_valid), 0);
        check("rst_cpl_tag", 32'(bus.cpl_tag), 0);
        check("rst_cpl_unit", 32'(bus.cpl_unit), 0);
        check("rst_cpl_err", 32'(bus.cpl_err), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ops_done", 32'(bus.ops_done), 0);

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        // FIFO full: unit 0 stalls; one popped plus DEPTH held before cmd_ready drops,
        // and the sixth waits until the pop after the first completion.
        umode[0]  = MODE_NORMAL;
        udelay[0] = 10;
        n = 0;
        cpl_c = -1;
        stall_seen = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_unit  = 2'd0;
        bus.cmd_tag   = 8'hA0;
        for (int c = 0; c < 400 && n < 6; c++) begin
            @(negedge clk);
            if (bus.cpl_valid && cpl_c < 0) cpl_c = c;
            if (bus.cmd_ready) begin
                if (n == 5) check("fifo_6th_wait", 32'(cpl_c >= 0 && (c - cpl_c) >= 2), 1);
                @(posedge clk); #1;
                n++;
                bus.cmd_tag = 8'hA0 + 8'(n);
                if (n == 6) bus.cmd_valid = 1'b0;
            end else if (!stall_seen) begin
                stall_seen = 1;
                check("fifo_accepted_at_full", n, 5);
            end
        end
        bus.cmd_valid = 1'b0;
        check("fifo_all_accepted", n, 6);
        check("fifo_went_full", 32'(stall_seen), 1);
        drain("fifo_drain");
        udelay[0] = 0;

        // Random traffic against the reference model, modes fixed per phase.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < NU; i++) begin
                int r;
                r = $urandom_range(0, 9);
                umode[i]  = (r == 0) ? MODE_NEVER : (r == 1) ? MODE_STUCK : MODE_NORMAL;
                udelay[i] = ($urandom_range(0, 9) == 0) ? 15 + $urandom_range(0, 1)
                                                        : $urandom_range(0, 6);
            end
            for (int k = 0; k < 40; k++) begin
                push(2'($urandom_range(0, 3)), 8'($urandom));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            drain("rand_drain");
            for (int i = 0; i < NU; i++) begin
                umode[i]  = MODE_NORMAL;
                udelay[i] = 0;
            end
            repeat (2) @(negedge clk);
        end

        // Reset while unit 1 is being driven, with more commands queued behind it.
        umode[1] = MODE_NEVER;
        push(2'd1, 8'h99);
        push(2'd0, 8'h9A);
        push(2'd2, 8'h9B);
        @(negedge clk);
        check("rstmid_go_before", 32'(bus.unit_go), 32'(3'b010));
        check("rstmid_ops_nonzero", 32'(bus.ops_done != 16'd0), 1);
        #2 rst_l = 1'b0;
        #1;
        check("rstmid_go_async", 32'(bus.unit_go), 0);
        check("rstmid_busy_async", 32'(bus.busy), 0);
        check("rstmid_ready_async", 32'(bus.cmd_ready), 1);
        check("rstmid_cpl_async", 32'(bus.cpl_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_l = 1'b1;
        umode[1] = MODE_NORMAL;
        repeat (6) @(negedge clk);
        check("rstmid_ops_after", 32'(bus.ops_done), 0);
        check("rstmid_busy_after", 32'(bus.busy), 0);
        check("rstmid_go_after", 32'(bus.unit_go), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no end of test after 1000000 ns, required completion");
        $fatal(1, "global timeout");
    end
endmodule
